// File: rtl/mem_pkg.sv
// Shared types for the load/store unit's BRAM port-A requester.
package mem_pkg;
  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_WAIT,
    RMW
  } lsu_state_e;
endpackage

// File: rtl/lsu_mem_port_if.sv
// Request/response handshake plus BRAM port-A signals of the LSU memory port.
interface lsu_mem_port_if #(
  parameter int MEM_AW = 14,
  parameter int XLEN   = 32
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [1:0]        req_size_i;
  logic              req_unsigned_i;
  logic [31:0]       req_addr_i;
  logic [XLEN-1:0]   req_wdata_i;
  logic              rsp_valid_o;
  logic [XLEN-1:0]   rsp_rdata_o;
  logic              rsp_err_o;
  logic              mem_we_o;
  logic [MEM_AW-1:0] mem_addr_o;
  logic [XLEN-1:0]   mem_wdata_o;
  logic [XLEN-1:0]   mem_rdata_i;

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    output mem_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  mem_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/lane_align.sv
// Byte/halfword lane handling: load extract+extend and store merge into an old word.
module lane_align
  import mem_pkg::*;
#(
  parameter int XLEN = mem_pkg::XLEN
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      offset,
  input  size_e           size,
  input  logic            ld_unsigned,
  input  logic [XLEN-1:0] st_new,
  output logic [XLEN-1:0] ld_data,
  output logic [XLEN-1:0] st_merged
);
  logic [4:0]      shamt;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] lane_mask;

  always_comb begin
    shamt     = {offset, 3'b000};
    shifted   = word >> shamt;
    ld_data   = word;
    lane_mask = '1;
    case (size)
      SZ_B: begin
        ld_data   = {{(XLEN-8){~ld_unsigned & shifted[7]}}, shifted[7:0]};
        lane_mask = {{(XLEN-8){1'b0}}, 8'hFF} << shamt;
      end
      SZ_H: begin
        ld_data   = {{(XLEN-16){~ld_unsigned & shifted[15]}}, shifted[15:0]};
        lane_mask = {{(XLEN-16){1'b0}}, 16'hFFFF} << shamt;
      end
      default: begin
        ld_data   = word;
        lane_mask = '1;
      end
    endcase
    st_merged = (word & ~lane_mask) | ((st_new << shamt) & lane_mask);
  end
endmodule

// File: rtl/lsu_mem_port.sv
// Load/store requester for BRAM port A: 1-cycle read latency, sub-word loads,
// and read-modify-write for byte/halfword stores (the BRAM has no byte enables).
//
// state     | meaning
// IDLE      | ready for a request; word stores and errors finish here
// LOAD_WAIT | BRAM read data arriving; extract/extend and register result
// RMW       | old word arriving; write back with the addressed lane(s) merged
module lsu_mem_port
  import mem_pkg::*;
#(
  parameter int MEM_AW = 14,
  parameter int XLEN   = mem_pkg::XLEN
) (
  input logic           clk_i,
  input logic           rst_ni,
  lsu_mem_port_if.slave bus
);
  localparam logic [32:0] ADDR_LIMIT = 33'd1 << MEM_AW;

  lsu_state_e        state_q, state_d;
  logic [MEM_AW-1:0] addr_q;
  size_e             size_q;
  logic              uns_q;
  logic [XLEN-1:0]   wdata_q;
  logic              rsp_valid_q, rsp_err_q;
  logic [XLEN-1:0]   rsp_rdata_q;

  size_e             req_size;
  logic              req_err, accept, ready;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN-1:0]   ld_data, st_merged;

  assign req_size = size_e'(bus.req_size_i);

  always_comb begin
    req_err = (req_size == SZ_RSV)
            | ((req_size == SZ_H) & bus.req_addr_i[0])
            | ((req_size == SZ_W) & (bus.req_addr_i[1:0] != 2'b00))
            | ({1'b0, bus.req_addr_i} >= ADDR_LIMIT);
  end

  lane_align #(.XLEN(XLEN)) u_lane_align (
    .word        (bus.mem_rdata_i),
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .ld_unsigned (uns_q),
    .st_new      (wdata_q),
    .ld_data     (ld_data),
    .st_merged   (st_merged)
  );

  always_comb begin
    state_d   = state_q;
    ready     = 1'b0;
    accept    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {addr_q[MEM_AW-1:2], 2'b00};
    mem_wdata = bus.req_wdata_i;
    case (state_q)
      IDLE: begin
        ready    = rst_ni;
        accept   = bus.req_valid_i & rst_ni;
        mem_addr = {bus.req_addr_i[MEM_AW-1:2], 2'b00};
        if (accept && !req_err) begin
          if (!bus.req_we_i)           state_d = LOAD_WAIT;
          else if (req_size == SZ_W)   mem_we  = 1'b1;
          else                         state_d = RMW;
        end
      end
      LOAD_WAIT: state_d = IDLE;
      RMW: begin
        mem_we    = 1'b1;
        mem_wdata = st_merged;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Async reset must silence the BRAM port immediately, not at the next edge.
    if (!rst_ni) begin
      mem_we   = 1'b0;
      mem_addr = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q      <= '0;
      size_q      <= SZ_B;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q  <= bus.req_addr_i[MEM_AW-1:0];
            size_q  <= req_size;
            uns_q   <= bus.req_unsigned_i;
            wdata_q <= bus.req_wdata_i;
            if (req_err) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else if (bus.req_we_i && req_size == SZ_W) begin
              rsp_valid_q <= 1'b1;
            end
          end
        end
        LOAD_WAIT: begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= ld_data;
        end
        RMW:     rsp_valid_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.req_ready_o = ready;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.mem_we_o    = mem_we;
  assign bus.mem_addr_o  = mem_addr;
  assign bus.mem_wdata_o = mem_wdata;
endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port with a 1-cycle registered BRAM model on port A.
module tb_lsu_mem_port;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lsu_mem_port_if #(.MEM_AW(14), .XLEN(32)) bus ();

  lsu_mem_port #(.MEM_AW(14), .XLEN(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  logic [31:0] mem [0:4095];
  logic [31:0] rd_q;
  always @(posedge clk) begin
    if (bus.mem_we_o === 1'b1) mem[bus.mem_addr_o[13:2]] <= bus.mem_wdata_o;
    rd_q <= mem[bus.mem_addr_o[13:2]];
  end
  assign bus.mem_rdata_i = rd_q;

  int we_cnt = 0;
  always @(posedge clk) if (bus.mem_we_o === 1'b1) we_cnt++;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    string       name;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  logic        s_we;
  logic [13:0] s_addr;
  logic [31:0] s_wdata;

  // Called just after a negedge; returns at the negedge opening cycle T+1.
  task automatic issue(input string nm, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input int lat);
    bus.req_we_i       = we;
    bus.req_size_i     = sz;
    bus.req_unsigned_i = uns;
    bus.req_addr_i     = addr;
    bus.req_wdata_i    = wd;
    bus.req_valid_i    = 1'b1;
    #1;
    total++;
    if (bus.req_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL %s ready: got %b want 1", nm, bus.req_ready_o);
    end
    s_we    = bus.mem_we_o;
    s_addr  = bus.mem_addr_o;
    s_wdata = bus.mem_wdata_o;
    if (lat > 0) sb.push_back('{rdata: exp_rd, err: exp_err, lat: lat, name: nm});
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_rsp();
    exp_t e;
    int   k;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard: response awaited with no expectation queued");
      return;
    end
    e = sb.pop_front();
    k = 1;
    while (bus.rsp_valid_o !== 1'b1 && k < 6) begin
      @(negedge clk);
      k++;
    end
    if (bus.rsp_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL %s rsp_valid: got %b want 1 within 5 cycles", e.name, bus.rsp_valid_o);
      return;
    end
    total++;
    if (k != e.lat) begin
      bad++;
      $display("FAIL %s latency: got %0d want %0d", e.name, k, e.lat);
    end
    total++;
    if (bus.rsp_rdata_o !== e.rdata) begin
      bad++;
      $display("FAIL %s rdata: got %h want %h", e.name, bus.rsp_rdata_o, e.rdata);
    end
    total++;
    if (bus.rsp_err_o !== e.err) begin
      bad++;
      $display("FAIL %s err: got %b want %b", e.name, bus.rsp_err_o, e.err);
    end
  endtask

  task automatic test_reset();
    rst_n              = 1'b0;
    bus.req_valid_i    = 1'b1;
    bus.req_we_i       = 1'b1;
    bus.req_size_i     = SZ_W;
    bus.req_unsigned_i = 1'b0;
    bus.req_addr_i     = 32'h0000_1234;
    bus.req_wdata_i    = 32'hFFFF_FFFF;
    #2;
    total += 5;
    if (bus.rsp_valid_o !== 1'b0) begin bad++; $display("FAIL reset rsp_valid: got %b want 0", bus.rsp_valid_o); end
    if (bus.rsp_rdata_o !== 32'h0) begin bad++; $display("FAIL reset rdata: got %h want 0", bus.rsp_rdata_o); end
    if (bus.rsp_err_o !== 1'b0) begin bad++; $display("FAIL reset err: got %b want 0", bus.rsp_err_o); end
    if (bus.mem_we_o !== 1'b0) begin bad++; $display("FAIL reset mem_we: got %b want 0", bus.mem_we_o); end
    if (bus.mem_addr_o !== 14'h0) begin bad++; $display("FAIL reset mem_addr: got %h want 0", bus.mem_addr_o); end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (we_cnt != 0) begin bad++; $display("FAIL reset writes: got %0d want 0", we_cnt); end
    bus.req_valid_i = 1'b0;
    rst_n           = 1'b1;
    #1;
    total++;
    if (bus.req_ready_o !== 1'b1) begin bad++; $display("FAIL reset release ready: got %b want 1", bus.req_ready_o); end
    @(negedge clk);
  endtask

  task automatic test_word_store_stream();
    issue("sw_0x00", 1'b1, SZ_W, 1'b0, 32'h00, 32'h1111_1111, 32'h0, 1'b0, 1);
    total += 3;
    if (s_we !== 1'b1) begin bad++; $display("FAIL sw_0x00 we@T: got %b want 1", s_we); end
    if (s_addr !== 14'h0) begin bad++; $display("FAIL sw_0x00 addr@T: got %h want 0", s_addr); end
    if (s_wdata !== 32'h1111_1111) begin bad++; $display("FAIL sw_0x00 wdata@T: got %h want 11111111", s_wdata); end
    check_rsp();
    issue("sw_0x10", 1'b1, SZ_W, 1'b0, 32'h10, 32'h8765_43A1, 32'h0, 1'b0, 1);
    check_rsp();
    issue("sw_0x14", 1'b1, SZ_W, 1'b0, 32'h14, 32'h0000_0000, 32'h0, 1'b0, 1);
    check_rsp();
  endtask

  task automatic test_load_word();
    int w0 = we_cnt;
    issue("lw_0x10", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h8765_43A1, 1'b0, 2);
    total += 2;
    if (s_we !== 1'b0) begin bad++; $display("FAIL lw_0x10 we@T: got %b want 0", s_we); end
    if (s_addr !== 14'h10) begin bad++; $display("FAIL lw_0x10 addr@T: got %h want 10", s_addr); end
    check_rsp();
    total++;
    if (we_cnt != w0) begin bad++; $display("FAIL lw_0x10 writes: got %0d want %0d", we_cnt, w0); end
  endtask

  task automatic test_subword_load();
    logic [31:0] w = 32'h8765_43A1;
    issue("lb_0x10",  1'b0, SZ_B, 1'b0, 32'h10, 32'h0, 32'hFFFF_FFA1, 1'b0, 2); check_rsp();
    issue("lbu_0x13", 1'b0, SZ_B, 1'b1, 32'h13, 32'h0, 32'h0000_0087, 1'b0, 2); check_rsp();
    issue("lh_0x12",  1'b0, SZ_H, 1'b0, 32'h12, 32'h0, 32'hFFFF_8765, 1'b0, 2); check_rsp();
    issue("lhu_0x12", 1'b0, SZ_H, 1'b1, 32'h12, 32'h0, 32'h0000_8765, 1'b0, 2); check_rsp();
    issue("lh_0x10",  1'b0, SZ_H, 1'b0, 32'h10, 32'h0, 32'h0000_43A1, 1'b0, 2); check_rsp();
    for (int off = 0; off < 4; off++) begin
      logic [7:0] b;
      b = w[8*off +: 8];
      issue($sformatf("lb_off%0d", off), 1'b0, SZ_B, 1'b0, 32'h10 + 32'(off), 32'h0,
            {{24{b[7]}}, b}, 1'b0, 2);
      check_rsp();
      issue($sformatf("lbu_off%0d", off), 1'b0, SZ_B, 1'b1, 32'h10 + 32'(off), 32'h0,
            {24'h0, b}, 1'b0, 2);
      check_rsp();
    end
  endtask

  task automatic test_store_rmw();
    int w0 = we_cnt;
    issue("sb_0x11", 1'b1, SZ_B, 1'b0, 32'h11, 32'h0000_00CC, 32'h0, 1'b0, 2);
    total += 5;
    if (s_we !== 1'b0) begin bad++; $display("FAIL sb_0x11 we@T: got %b want 0", s_we); end
    if (s_addr !== 14'h10) begin bad++; $display("FAIL sb_0x11 addr@T: got %h want 10", s_addr); end
    if (bus.mem_we_o !== 1'b1) begin bad++; $display("FAIL sb_0x11 we@T+1: got %b want 1", bus.mem_we_o); end
    if (bus.mem_addr_o !== 14'h10) begin bad++; $display("FAIL sb_0x11 addr@T+1: got %h want 10", bus.mem_addr_o); end
    if (bus.mem_wdata_o !== 32'h8765_CCA1) begin bad++; $display("FAIL sb_0x11 wdata@T+1: got %h want 8765cca1", bus.mem_wdata_o); end
    check_rsp();
    total++;
    if (we_cnt != w0 + 1) begin bad++; $display("FAIL sb_0x11 writes: got %0d want %0d", we_cnt, w0 + 1); end
    issue("lw_after_sb", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h8765_CCA1, 1'b0, 2); check_rsp();
    issue("sb_0x13", 1'b1, SZ_B, 1'b0, 32'h13, 32'hABCD_EF12, 32'h0, 1'b0, 2); check_rsp();
    issue("sh_0x10", 1'b1, SZ_H, 1'b0, 32'h10, 32'hFFFF_5A5A, 32'h0, 1'b0, 2); check_rsp();
    issue("lw_after_sh", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h1265_5A5A, 1'b0, 2); check_rsp();
  endtask

  task automatic test_back_to_back();
    issue("sw_0x14_dead", 1'b1, SZ_W, 1'b0, 32'h14, 32'hDEAD_BEEF, 32'h0, 1'b0, 1);
    total++;
    if (s_we !== 1'b1) begin bad++; $display("FAIL sw_0x14_dead we@T: got %b want 1", s_we); end
    check_rsp();
    issue("lw_in_rsp_cycle", 1'b0, SZ_W, 1'b0, 32'h14, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);
    check_rsp();
  endtask

  task automatic test_errors();
    logic        e_we   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0]  e_sz   [5] = '{SZ_H, SZ_W, SZ_RSV, SZ_W, SZ_W};
    logic [31:0] e_addr [5] = '{32'h11, 32'h12, 32'h0, 32'h4000, 32'h4000};
    for (int i = 0; i < 5; i++) begin
      int w0 = we_cnt;
      issue($sformatf("err%0d", i), e_we[i], e_sz[i], 1'b0, e_addr[i], 32'hCAFE_F00D,
            32'h0, 1'b1, 1);
      total++;
      if (s_we !== 1'b0) begin bad++; $display("FAIL err%0d we@T: got %b want 0", i, s_we); end
      check_rsp();
      total++;
      if (we_cnt != w0) begin bad++; $display("FAIL err%0d writes: got %0d want %0d", i, we_cnt, w0); end
    end
    total += 2;
    if (mem[0] !== 32'h1111_1111) begin bad++; $display("FAIL err mem[0x0]: got %h want 11111111", mem[0]); end
    if (mem[4] !== 32'h1265_5A5A) begin bad++; $display("FAIL err mem[0x10]: got %h want 12655a5a", mem[4]); end
  endtask

  task automatic test_reset_in_rmw();
    int seen = 0;
    issue("sh_0x16_rst", 1'b1, SZ_H, 1'b0, 32'h16, 32'h0000_1234, 32'h0, 1'b0, 0);
    total++;
    if (bus.mem_we_o !== 1'b1) begin bad++; $display("FAIL rmw_rst we before reset: got %b want 1", bus.mem_we_o); end
    rst_n = 1'b0;
    #1;
    total += 2;
    if (bus.mem_we_o !== 1'b0) begin bad++; $display("FAIL rmw_rst we in reset: got %b want 0", bus.mem_we_o); end
    if (bus.mem_addr_o !== 14'h0) begin bad++; $display("FAIL rmw_rst addr in reset: got %h want 0", bus.mem_addr_o); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total += 2;
    if (bus.req_ready_o !== 1'b1) begin bad++; $display("FAIL rmw_rst ready after release: got %b want 1", bus.req_ready_o); end
    if (mem[5] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rmw_rst mem[0x14]: got %h want deadbeef", mem[5]); end
    for (int i = 0; i < 3; i++) begin
      if (bus.rsp_valid_o === 1'b1) seen++;
      @(negedge clk);
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL rmw_rst rsp_valid pulses: got %0d want 0", seen); end
    issue("lw_after_rst", 1'b0, SZ_W, 1'b0, 32'h14, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);
    check_rsp();
  endtask

  initial begin
    test_reset();
    test_word_store_stream();
    test_load_word();
    test_subword_load();
    test_store_rmw();
    test_back_to_back();
    test_errors();
    test_reset_in_rmw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end
endmodule
